// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU VRAM address register and background fetch path.
package ppu_pkg;

    // Current/temporary VRAM address layout: fine_y[14:12] v_nt[11] h_nt[10] coarse_y[9:5] coarse_x[4:0]
    typedef struct packed {
        logic [2:0] fine_y;
        logic       v_nt;
        logic       h_nt;
        logic [4:0] coarse_y;
        logic [4:0] coarse_x;
    } vaddr_t;

    typedef enum logic [2:0] {
        PH_TILE_DONE = 3'd0,
        PH_NT_ADDR   = 3'd1,
        PH_NT_DATA   = 3'd2,
        PH_AT_ADDR   = 3'd3,
        PH_AT_DATA   = 3'd4,
        PH_LO_ADDR   = 3'd5,
        PH_LO_DATA   = 3'd6,
        PH_HI_ADDR   = 3'd7
    } fetch_phase_e;

    localparam logic [13:0] NT_BASE  = 14'h2000;
    localparam logic [13:0] AT_BASE  = 14'h23C0;
    localparam logic [5:0]  PAL_BASE = 6'h3F;

    localparam logic [8:0] DOT_YINC    = 9'd256;
    localparam logic [8:0] DOT_HCOPY   = 9'd257;
    localparam logic [8:0] VCOPY_FIRST = 9'd280;
    localparam logic [8:0] VCOPY_LAST  = 9'd304;
    localparam logic [8:0] PF_FIRST    = 9'd321;
    localparam logic [8:0] PF_LAST     = 9'd336;

endpackage

// File: rtl/ppu_scroll_inc.sv
// Combinational scroll increments of v: coarse-X step, and coarse-X followed by the Y step.
module ppu_scroll_inc
    import ppu_pkg::*;
(
    input  vaddr_t v_i,
    output vaddr_t v_x_o,
    output vaddr_t v_xy_o
);

    function automatic vaddr_t inc_x(input vaddr_t v);
        vaddr_t r;
        r = v;
        if (v.coarse_x == 5'd31) begin
            r.coarse_x = 5'd0;
            r.h_nt     = ~v.h_nt;
        end else begin
            r.coarse_x = v.coarse_x + 5'd1;
        end
        return r;
    endfunction

    // Rows 30/31 are attribute space; entering them via $2006 wraps without a nametable switch.
    function automatic vaddr_t inc_y(input vaddr_t v);
        vaddr_t r;
        r = v;
        if (v.fine_y != 3'd7) begin
            r.fine_y = v.fine_y + 3'd1;
        end else begin
            r.fine_y = 3'd0;
            if (v.coarse_y == 5'd29) begin
                r.coarse_y = 5'd0;
                r.v_nt     = ~v.v_nt;
            end else if (v.coarse_y == 5'd31) begin
                r.coarse_y = 5'd0;
            end else begin
                r.coarse_y = v.coarse_y + 5'd1;
            end
        end
        return r;
    endfunction

    assign v_x_o  = inc_x(v_i);
    assign v_xy_o = inc_y(v_x_o);

endmodule

// File: rtl/ppu_vaddr_fetch.sv
// PPU current VRAM address (v) owner and 8-dot background tile fetcher.
module ppu_vaddr_fetch
    import ppu_pkg::*;
#(
    parameter int VISIBLE_LINES  = 240,
    parameter int PRERENDER_LINE = 261
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        pix_pulse_in,
    input  logic [8:0]  dot_in,
    input  logic [8:0]  scanline_in,
    input  logic        rendering_en_in,
    input  logic        bg_pat_addr_in,
    input  logic        upd_cntrs_in,
    input  logic        inc_addr_in,
    input  logic        inc_amt_in,
    input  logic [2:0]  fine_v_in,
    input  logic [4:0]  v_tile_index_in,
    input  logic        v_nt_sel_in,
    input  logic [4:0]  h_tile_index_in,
    input  logic        h_nt_sel_in,
    input  logic [7:0]  vram_data_in,
    output logic [13:0] vram_addr_out,
    output logic [7:0]  nt_byte_out,
    output logic [1:0]  at_bits_out,
    output logic [7:0]  pt_lo_out,
    output logic [7:0]  pt_hi_out,
    output logic        tile_valid_out
);

    localparam logic [8:0] VIS_LINES = 9'(VISIBLE_LINES);
    localparam logic [8:0] PRE_LINE  = 9'(PRERENDER_LINE);

    vaddr_t       v_q, v_d, t_fields, v_xinc, v_xyinc;
    logic [13:0]  fetch_addr_q;
    logic [7:0]   nt_q, pt_lo_q;
    logic [1:0]   at_q;
    logic [7:0]   nt_out_q, pt_lo_out_q, pt_hi_out_q;
    logic [1:0]   at_out_q;
    logic         tile_valid_q;
    logic         active, fetch_win, tile_step, vcopy_win;
    fetch_phase_e phase;
    logic [2:0]   at_shift;
    logic [1:0]   at_sel;

    assign t_fields  = {fine_v_in, v_nt_sel_in, h_nt_sel_in, v_tile_index_in, h_tile_index_in};
    assign active    = rendering_en_in && ((scanline_in < VIS_LINES) || (scanline_in == PRE_LINE));
    assign fetch_win = ((dot_in >= 9'd1) && (dot_in <= 9'd256)) ||
                       ((dot_in >= PF_FIRST) && (dot_in <= PF_LAST));
    assign phase     = fetch_phase_e'(dot_in[2:0]);
    assign tile_step = pix_pulse_in && active && fetch_win;
    assign vcopy_win = (scanline_in == PRE_LINE) && (dot_in >= VCOPY_FIRST) && (dot_in <= VCOPY_LAST);
    // Each attribute byte covers a 4x4-tile block; coarse bit 1 of X/Y picks the 2-bit quadrant.
    assign at_shift  = {v_q.coarse_y[1], v_q.coarse_x[1], 1'b0};
    assign at_sel    = 2'(vram_data_in >> at_shift);

    ppu_scroll_inc u_scroll_inc (
        .v_i    (v_q),
        .v_x_o  (v_xinc),
        .v_xy_o (v_xyinc)
    );

    always_comb begin
        v_d = v_q;
        if (upd_cntrs_in) begin
            v_d = t_fields;
        end else if (inc_addr_in) begin
            v_d = v_q + (inc_amt_in ? 15'd32 : 15'd1);
        end else if (pix_pulse_in && active) begin
            if (fetch_win && (dot_in[2:0] == 3'd0)) begin
                v_d = (dot_in == DOT_YINC) ? v_xyinc : v_xinc;
            end
            if (dot_in == DOT_HCOPY) begin
                v_d.coarse_x = t_fields.coarse_x;
                v_d.h_nt     = t_fields.h_nt;
            end
            if (vcopy_win) begin
                v_d.fine_y   = t_fields.fine_y;
                v_d.v_nt     = t_fields.v_nt;
                v_d.coarse_y = t_fields.coarse_y;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            v_q          <= '0;
            fetch_addr_q <= '0;
            nt_q         <= '0;
            at_q         <= '0;
            pt_lo_q      <= '0;
            nt_out_q     <= '0;
            at_out_q     <= '0;
            pt_lo_out_q  <= '0;
            pt_hi_out_q  <= '0;
            tile_valid_q <= 1'b0;
        end else begin
            v_q          <= v_d;
            tile_valid_q <= 1'b0;
            if (tile_step) begin
                unique case (phase)
                    PH_NT_ADDR:   fetch_addr_q <= NT_BASE | {2'b00, v_q[11:0]};
                    PH_NT_DATA:   nt_q <= vram_data_in;
                    PH_AT_ADDR:   fetch_addr_q <= AT_BASE | {2'b00, v_q.v_nt, v_q.h_nt, 4'b0000,
                                                             v_q.coarse_y[4:2], v_q.coarse_x[4:2]};
                    PH_AT_DATA:   at_q <= at_sel;
                    PH_LO_ADDR:   fetch_addr_q <= {1'b0, bg_pat_addr_in, nt_q, 1'b0, v_q.fine_y};
                    PH_LO_DATA:   pt_lo_q <= vram_data_in;
                    // High plane sits 8 bytes above the low plane of the same row.
                    PH_HI_ADDR:   fetch_addr_q <= {1'b0, bg_pat_addr_in, nt_q, 1'b1, v_q.fine_y};
                    PH_TILE_DONE: begin
                        nt_out_q     <= nt_q;
                        at_out_q     <= at_q;
                        pt_lo_out_q  <= pt_lo_q;
                        pt_hi_out_q  <= vram_data_in;
                        tile_valid_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign vram_addr_out  = (active && fetch_win) ? fetch_addr_q : v_q[13:0];
    assign nt_byte_out    = nt_out_q;
    assign at_bits_out    = at_out_q;
    assign pt_lo_out      = pt_lo_out_q;
    assign pt_hi_out      = pt_hi_out_q;
    assign tile_valid_out = tile_valid_q;

endmodule

// File: tb/tb_ppu_vaddr_fetch.sv
// Self-checking bench for ppu_vaddr_fetch: directed scroll/fetch cases plus randomized scanlines vs a model.
module tb_ppu_vaddr_fetch;

    logic        clk_in = 1'b0;
    logic        rst_in, pix_pulse_in, rendering_en_in, bg_pat_addr_in;
    logic        upd_cntrs_in, inc_addr_in, inc_amt_in, v_nt_sel_in, h_nt_sel_in;
    logic [8:0]  dot_in, scanline_in;
    logic [2:0]  fine_v_in;
    logic [4:0]  v_tile_index_in, h_tile_index_in;
    logic [7:0]  vram_data_in;
    logic [13:0] vram_addr_out;
    logic [7:0]  nt_byte_out, pt_lo_out, pt_hi_out;
    logic [1:0]  at_bits_out;
    logic        tile_valid_out;

    always #5 clk_in = ~clk_in;

    ppu_vaddr_fetch dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .pix_pulse_in    (pix_pulse_in),
        .dot_in          (dot_in),
        .scanline_in     (scanline_in),
        .rendering_en_in (rendering_en_in),
        .bg_pat_addr_in  (bg_pat_addr_in),
        .upd_cntrs_in    (upd_cntrs_in),
        .inc_addr_in     (inc_addr_in),
        .inc_amt_in      (inc_amt_in),
        .fine_v_in       (fine_v_in),
        .v_tile_index_in (v_tile_index_in),
        .v_nt_sel_in     (v_nt_sel_in),
        .h_tile_index_in (h_tile_index_in),
        .h_nt_sel_in     (h_nt_sel_in),
        .vram_data_in    (vram_data_in),
        .vram_addr_out   (vram_addr_out),
        .nt_byte_out     (nt_byte_out),
        .at_bits_out     (at_bits_out),
        .pt_lo_out       (pt_lo_out),
        .pt_hi_out       (pt_hi_out),
        .tile_valid_out  (tile_valid_out)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  mem [0:16383];
    logic [14:0] t_val;
    logic        seen_valid;

    // Reference model state: v as separate fields, fetch latches, and the tile outputs.
    int m_fy, m_vnt, m_hnt, m_cy, m_cx;
    int m_addr, m_nt, m_at, m_lo;
    int o_nt, o_at, o_lo, o_hi;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int m_v();
        return m_fy * 4096 + m_vnt * 2048 + m_hnt * 1024 + m_cy * 32 + m_cx;
    endfunction

    function automatic void m_set_v(input int val);
        m_cx  = val % 32;
        m_cy  = (val / 32) % 32;
        m_hnt = (val / 1024) % 2;
        m_vnt = (val / 2048) % 2;
        m_fy  = (val / 4096) % 8;
    endfunction

    function automatic bit m_active();
        return rendering_en_in && (int'(scanline_in) < 240 || int'(scanline_in) == 261);
    endfunction

    function automatic bit m_fw(input int d);
        return (d >= 1 && d <= 256) || (d >= 321 && d <= 336);
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_t(input logic [14:0] tv);
        t_val           = tv;
        fine_v_in       = tv[14:12];
        v_nt_sel_in     = tv[11];
        h_nt_sel_in     = tv[10];
        v_tile_index_in = tv[9:5];
        h_tile_index_in = tv[4:0];
    endtask

    task automatic load_v(input logic [14:0] tv);
        set_t(tv);
        upd_cntrs_in = 1'b1;
        step();
        upd_cntrs_in = 1'b0;
        m_set_v(int'(tv));
    endtask

    task automatic inc_v(input logic amt);
        inc_amt_in  = amt;
        inc_addr_in = 1'b1;
        step();
        inc_addr_in = 1'b0;
        m_set_v((m_v() + (amt ? 32 : 1)) % 32768);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
        m_set_v(0);
        m_addr = 0; m_nt = 0; m_at = 0; m_lo = 0;
        o_nt = 0; o_at = 0; o_lo = 0; o_hi = 0;
    endtask

    task automatic model_pulse(input int d, output bit exp_valid);
        int quad, col;
        exp_valid = 1'b0;
        if (m_active()) begin
            if (m_fw(d)) begin
                case (d % 8)
                    1: m_addr = 'h2000 + (m_v() % 4096);
                    2: m_nt = int'(mem[m_addr]);
                    3: m_addr = 'h23C0 + m_vnt * 2048 + m_hnt * 1024 + (m_cy / 4) * 8 + (m_cx / 4);
                    4: begin
                        quad = ((m_cy / 2) % 2) * 2 + (m_cx / 2) % 2;
                        m_at = (int'(mem[m_addr]) >> (2 * quad)) % 4;
                    end
                    5: m_addr = int'(bg_pat_addr_in) * 4096 + m_nt * 16 + m_fy;
                    6: m_lo = int'(mem[m_addr]);
                    7: m_addr = m_addr + 8;
                    default: begin
                        o_nt = m_nt; o_at = m_at; o_lo = m_lo; o_hi = int'(mem[m_addr]);
                        exp_valid = 1'b1;
                        col   = (m_hnt * 32 + m_cx + 1) % 64;
                        m_hnt = col / 32;
                        m_cx  = col % 32;
                    end
                endcase
            end
            if (d == 256) begin
                if (m_fy < 7) m_fy++;
                else begin
                    m_fy = 0;
                    if (m_cy == 29) begin m_cy = 0; m_vnt = 1 - m_vnt; end
                    else if (m_cy == 31) m_cy = 0;
                    else m_cy++;
                end
            end
            if (d == 257) begin
                m_cx  = int'(t_val[4:0]);
                m_hnt = int'(t_val[10]);
            end
            if (int'(scanline_in) == 261 && d >= 280 && d <= 304) begin
                m_fy  = int'(t_val[14:12]);
                m_vnt = int'(t_val[11]);
                m_cy  = int'(t_val[9:5]);
            end
        end
    endtask

    // One dot: pulse cycle followed by an idle cycle; memory answers from the address on the bus.
    task automatic run_dot(input int d);
        bit ev;
        dot_in = 9'(d);
        #1;
        if (!(m_active() && m_fw(d)))
            check_eq("addr_is_v", 32'(vram_addr_out), m_v() % 16384);
        else if (d % 2 == 0)
            check_eq("addr_fetch", 32'(vram_addr_out), m_addr);
        vram_data_in = mem[vram_addr_out];
        pix_pulse_in = 1'b1;
        step();
        pix_pulse_in = 1'b0;
        model_pulse(d, ev);
        seen_valid = tile_valid_out;
        check_eq("tile_valid", 32'(tile_valid_out), 32'(ev));
        if (ev) begin
            check_eq("nt_byte", 32'(nt_byte_out), o_nt);
            check_eq("at_bits", 32'(at_bits_out), o_at);
            check_eq("pt_lo", 32'(pt_lo_out), o_lo);
            check_eq("pt_hi", 32'(pt_hi_out), o_hi);
        end
        step();
        check_eq("tv_clear", 32'(tile_valid_out), 0);
    endtask

    task automatic run_line(input int scan, input logic ren);
        scanline_in     = 9'(scan);
        rendering_en_in = ren;
        bg_pat_addr_in  = 1'($urandom_range(0, 1));
        load_v(15'($urandom));
        set_t(15'($urandom));
        for (int d = 0; d <= 340; d++) run_dot(d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_in = 1'b1; pix_pulse_in = 1'b0; rendering_en_in = 1'b0; bg_pat_addr_in = 1'b0;
        upd_cntrs_in = 1'b0; inc_addr_in = 1'b0; inc_amt_in = 1'b0;
        dot_in = '0; scanline_in = '0; vram_data_in = '0;
        set_t('0);
        for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
        step();
        do_reset();

        check_eq("rst_addr", 32'(vram_addr_out), 0);
        check_eq("rst_tv", 32'(tile_valid_out), 0);
        check_eq("rst_nt", 32'(nt_byte_out), 0);
        check_eq("rst_at", 32'(at_bits_out), 0);
        check_eq("rst_lo", 32'(pt_lo_out), 0);
        check_eq("rst_hi", 32'(pt_hi_out), 0);

        load_v({3'd3, 1'b1, 1'b0, 5'd5, 5'd7});
        check_eq("upd_load", 32'(vram_addr_out), 'h38A7);

        load_v(15'h2000);
        inc_v(1'b1); inc_v(1'b1); inc_v(1'b1);
        check_eq("inc32x3", 32'(vram_addr_out), 'h2060);
        inc_v(1'b0);
        check_eq("inc1", 32'(vram_addr_out), 'h2061);
        load_v(15'h7FFF);
        check_eq("load_7fff", 32'(vram_addr_out), 'h3FFF);
        inc_v(1'b0);
        check_eq("inc_wrap", 32'(vram_addr_out), 0);

        scanline_in = 9'd0;
        load_v(15'd31);
        rendering_en_in = 1'b1;
        run_dot(8);
        rendering_en_in = 1'b0;
        #1;
        check_eq("xwrap", 32'(vram_addr_out), 'h0400);

        load_v({3'd7, 1'b0, 1'b0, 5'd29, 5'd0});
        rendering_en_in = 1'b1;
        run_dot(256);
        rendering_en_in = 1'b0;
        #1;
        check_eq("ywrap29", 32'(vram_addr_out), 'h0801);

        load_v({3'd7, 1'b0, 1'b0, 5'd31, 5'd0});
        rendering_en_in = 1'b1;
        run_dot(256);
        rendering_en_in = 1'b0;
        #1;
        check_eq("ywrap31", 32'(vram_addr_out), 'h0001);

        mem[14'h2000] = 8'h42; mem[14'h2002] = 8'h42; mem[14'h23C0] = 8'hE4;
        mem[14'h1420] = 8'hAA; mem[14'h1428] = 8'h55;
        bg_pat_addr_in = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            load_v(pass == 0 ? 15'd0 : 15'd2);
            rendering_en_in = 1'b1;
            run_dot(1); check_eq("f_nt_addr", 32'(vram_addr_out), 'h2000 + 2 * pass);
            run_dot(2);
            run_dot(3); check_eq("f_at_addr", 32'(vram_addr_out), 'h23C0);
            run_dot(4);
            run_dot(5); check_eq("f_lo_addr", 32'(vram_addr_out), 'h1420);
            run_dot(6);
            run_dot(7); check_eq("f_hi_addr", 32'(vram_addr_out), 'h1428);
            run_dot(8);
            check_eq("f_valid", 32'(seen_valid), 1);
            check_eq("f_nt", 32'(nt_byte_out), 'h42);
            check_eq("f_at", 32'(at_bits_out), pass);
            check_eq("f_lo", 32'(pt_lo_out), 'hAA);
            check_eq("f_hi", 32'(pt_hi_out), 'h55);
            rendering_en_in = 1'b0;
        end

        scanline_in = 9'd261;
        load_v(15'($urandom));
        set_t({3'd5, 1'b1, 1'b0, 5'd12, 5'd3});
        rendering_en_in = 1'b1;
        for (int d = 0; d <= 280; d++) begin
            run_dot(d);
            if (d == 257) check_eq("hcopy", 32'(vram_addr_out & 14'h041F), 'h0003);
        end
        check_eq("vcopy", 32'(vram_addr_out), 'h1983);

        scanline_in = 9'd0;
        load_v(15'($urandom));
        for (int d = 1; d <= 9; d++) begin
            rendering_en_in = (d < 5);
            run_dot(d);
            if (d == 8) check_eq("drop_no_valid", 32'(seen_valid), 0);
        end
        check_eq("drop_addr", 32'(vram_addr_out), m_v() % 16384);
        check_eq("drop_kept_nt", 32'(nt_byte_out), o_nt);

        rendering_en_in = 1'b0;
        load_v(15'h0123);
        set_t(15'h1ABC);
        upd_cntrs_in = 1'b1; inc_addr_in = 1'b1; inc_amt_in = 1'b1;
        step();
        upd_cntrs_in = 1'b0; inc_addr_in = 1'b0;
        m_set_v('h1ABC);
        check_eq("upd_wins", 32'(vram_addr_out), 'h1ABC);

        for (int k = 0; k < 8; k++) begin
            case (k % 4)
                0: run_line($urandom_range(0, 239), 1'b1);
                1: run_line(261, 1'b1);
                2: run_line($urandom_range(240, 260), 1'b1);
                default: run_line($urandom_range(0, 239), 1'b0);
            endcase
        end

        scanline_in = 9'd0;
        rendering_en_in = 1'b1;
        load_v(15'($urandom));
        run_dot(1); run_dot(2); run_dot(3);
        do_reset();
        check_eq("mid_rst_addr", 32'(vram_addr_out), 0);
        check_eq("mid_rst_tv", 32'(tile_valid_out), 0);
        check_eq("mid_rst_nt", 32'(nt_byte_out), 0);
        check_eq("mid_rst_hi", 32'(pt_hi_out), 0);
        for (int d = 4; d <= 16; d++) run_dot(d);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
